// File: rtl/kitchen_pkg.sv
// Shared constants and types for the kitchen load scheduler: appliance indices,
// default sizing and the chimney sequencer state encoding.
package kitchen_pkg;

  localparam int STOVE     = 0;
  localparam int OVEN      = 1;
  localparam int KETTLE    = 2;
  localparam int MICROWAVE = 3;

  localparam int DEF_N_APPL       = 4;
  localparam int DEF_MAX_ON       = 2;
  localparam int DEF_CHIMNEY_HOLD = 60;
  localparam logic [3:0] DEF_HEAT_MASK = 4'((1 << STOVE) | (1 << OVEN));

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    PURGE = 2'd2
  } chimney_state_e;

endpackage

// File: rtl/kitchen_chimney_seq.sv
// Chimney sequencer: runs while any heat source is granted, then purges for
// CHIMNEY_HOLD cycles after the last one drops.
module kitchen_chimney_seq
  import kitchen_pkg::*;
#(
  parameter int CHIMNEY_HOLD = DEF_CHIMNEY_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic heat,
  output logic chimney
);

  localparam int CW = (CHIMNEY_HOLD > 1) ? $clog2(CHIMNEY_HOLD) : 1;

  chimney_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           chimney_q, chimney_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      chimney_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      chimney_q <= chimney_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (heat) state_d = RUN;
      end
      RUN: begin
        if (!heat) begin
          state_d = PURGE;
          cnt_d   = CW'(CHIMNEY_HOLD - 1);
        end
      end
      PURGE: begin
        // A returning heat source cancels the purge; the next drop reloads it.
        if (heat)             state_d = RUN;
        else if (cnt_q == '0) state_d = OFF;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = OFF;
    endcase
    chimney_d = (state_d != OFF);
  end

  assign chimney = chimney_q;

endmodule

// File: rtl/kitchen_load_scheduler.sv
// Round-robin power-budget arbiter for kitchen appliances (at most MAX_ON granted,
// no preemption, one new grant per cycle) driving the chimney sequencer.
module kitchen_load_scheduler
  import kitchen_pkg::*;
#(
  parameter int                N_APPL       = DEF_N_APPL,
  parameter int                MAX_ON       = DEF_MAX_ON,
  parameter logic [N_APPL-1:0] HEAT_MASK    = N_APPL'(DEF_HEAT_MASK),
  parameter int                CHIMNEY_HOLD = DEF_CHIMNEY_HOLD
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_APPL-1:0]           req,
  output logic [N_APPL-1:0]           grant,
  output logic                        chimney,
  output logic [$clog2(N_APPL+1)-1:0] active_cnt,
  output logic                        pending
);

  localparam int PW = (N_APPL > 1) ? $clog2(N_APPL) : 1;
  localparam int AW = $clog2(N_APPL + 1);

  logic [N_APPL-1:0] grant_q, grant_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]     active_cnt_q, active_cnt_d;
  logic              pending_q, pending_d;

  logic [N_APPL-1:0] kept;
  logic [AW-1:0]     kept_cnt;
  logic [PW-1:0]     idx;
  logic [PW-1:0]     pick;
  logic              found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      active_cnt_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      active_cnt_q <= active_cnt_d;
      pending_q    <= pending_d;
    end
  end

  always_comb begin
    // Released slots free up on the same edge, so capacity is judged on kept grants.
    kept     = grant_q & req;
    kept_cnt = '0;
    for (int i = 0; i < N_APPL; i++) kept_cnt = kept_cnt + AW'(kept[i]);

    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_APPL; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % N_APPL);
      if (!found && req[idx] && !kept[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    grant_d  = kept;
    rr_ptr_d = rr_ptr_q;
    if (found && (int'(kept_cnt) < MAX_ON)) begin
      grant_d[pick] = 1'b1;
      rr_ptr_d      = PW'((int'(pick) + 1) % N_APPL);
    end

    active_cnt_d = '0;
    for (int i = 0; i < N_APPL; i++) active_cnt_d = active_cnt_d + AW'(grant_d[i]);
    pending_d = |(req & ~grant_d);
  end

  kitchen_chimney_seq #(
    .CHIMNEY_HOLD(CHIMNEY_HOLD)
  ) u_chimney (
    .clk    (clk),
    .rst_n  (rst_n),
    .heat   (|(grant_q & HEAT_MASK)),
    .chimney(chimney)
  );

  assign grant      = grant_q;
  assign active_cnt = active_cnt_q;
  assign pending    = pending_q;

endmodule
